// File: rtl/loader_pkg.sv
// Constants shared by the imem loader, the fetch/decode/execute core and its imem.
// The FSM state codes are plain 2-bit constants so older code that uses them still compiles.
package loader_pkg;

   localparam int LOADER_DATA_W = 32;
   localparam int LOADER_ADDR_W = 5;

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_LOAD   = 2'd1;
   localparam logic [1:0] S_VERIFY = 2'd2;
   localparam logic [1:0] S_DONE   = 2'd3;

endpackage

// File: rtl/sum32_acc.sv
// Registered running sum. The sum wraps modulo 2^W.
// Clear takes priority over enable.
module sum32_acc
   import loader_pkg::*;
#(
   parameter int W = LOADER_DATA_W
) (
   input  logic         i_clk,
   input  logic         i_rst_n,
   input  logic         i_clear,
   input  logic         i_en,
   input  logic [W-1:0] i_in,
   output logic [W-1:0] o_sum
);

   logic [W-1:0] r_sum;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_sum <= '0;
      end else if (i_clear) begin
         r_sum <= '0;
      end else if (i_en) begin
         r_sum <= r_sum + i_in;
      end
   end

   assign o_sum = r_sum;

endmodule

// File: rtl/imem_loader.sv
// Streams program words into imem from address 0, then reads the image back to check it.
// When the readback sum matches the write checksum, the core is released from hold.
module imem_loader
   import loader_pkg::*;
#(
   parameter int ADDR_W = LOADER_ADDR_W,
   parameter int DATA_W = LOADER_DATA_W
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_start,
   input  logic [ADDR_W:0]   i_word_count,
   input  logic              i_in_valid,
   input  logic [DATA_W-1:0] i_in_data,
   output logic              o_in_ready,
   output logic              o_mem_we,
   output logic              o_mem_re,
   output logic [ADDR_W-1:0] o_mem_addr,
   output logic [DATA_W-1:0] o_mem_wdata,
   input  logic [DATA_W-1:0] i_mem_rdata,
   output logic              o_core_hold,
   output logic              o_done,
   output logic              o_error,
   output logic [DATA_W-1:0] o_checksum
);

   localparam logic [ADDR_W:0] C_DEPTH = {1'b1, {ADDR_W{1'b0}}};

   logic [1:0]        r_state;
   logic [ADDR_W:0]   r_cnt;
   logic [ADDR_W:0]   r_wr_ptr;
   logic [ADDR_W:0]   r_rd_ptr;
   logic              r_rd_valid;
   logic              r_oversize;

   logic              w_start_ok;
   logic              w_accept;
   logic              w_last_wr;
   logic              w_issue_rd;
   logic              w_verify_end;
   logic [DATA_W-1:0] w_checksum;
   logic [DATA_W-1:0] w_rd_sum;

   // A start pulse is only honoured between loads.
   assign w_start_ok   = i_start && ((r_state == S_IDLE) || (r_state == S_DONE));
   assign w_accept     = (r_state == S_LOAD) && i_in_valid;
   assign w_last_wr    = w_accept && ((r_wr_ptr + 1'b1) == r_cnt);
   assign w_issue_rd   = (r_state == S_VERIFY) && (r_rd_ptr != r_cnt);
   // All reads issued and the final read word is on i_mem_rdata this cycle.
   assign w_verify_end = (r_state == S_VERIFY) && (r_rd_ptr == r_cnt) && r_rd_valid;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state    <= S_IDLE;
         r_cnt      <= '0;
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_rd_valid <= 1'b0;
         r_oversize <= 1'b0;
      end else if (w_start_ok) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_rd_valid <= 1'b0;
         r_oversize <= 1'b0;
         if (i_word_count == '0) begin
            r_state <= S_DONE;
         end else if (i_word_count > C_DEPTH) begin
            r_state    <= S_DONE;
            r_oversize <= 1'b1;
         end else begin
            r_cnt   <= i_word_count;
            r_state <= S_LOAD;
         end
      end else begin
         r_rd_valid <= w_issue_rd;
         case (r_state)
            S_LOAD: begin
               if (w_accept) begin
                  r_wr_ptr <= r_wr_ptr + 1'b1;
               end
               if (w_last_wr) begin
                  r_state <= S_VERIFY;
               end
            end
            S_VERIFY: begin
               if (w_issue_rd) begin
                  r_rd_ptr <= r_rd_ptr + 1'b1;
               end
               if (w_verify_end) begin
                  r_state <= S_DONE;
               end
            end
            default: ;
         endcase
      end
   end

   sum32_acc #(.W(DATA_W)) u_wr_sum (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_clear (w_start_ok),
      .i_en    (w_accept),
      .i_in    (i_in_data),
      .o_sum   (w_checksum)
   );

   sum32_acc #(.W(DATA_W)) u_rd_sum (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_clear (w_start_ok),
      .i_en    (r_rd_valid),
      .i_in    (i_mem_rdata),
      .o_sum   (w_rd_sum)
   );

   assign o_in_ready  = (r_state == S_LOAD);
   assign o_mem_we    = w_accept;
   assign o_mem_re    = w_issue_rd;
   assign o_mem_addr  = (r_state == S_LOAD)   ? r_wr_ptr[ADDR_W-1:0] :
                        (r_state == S_VERIFY) ? r_rd_ptr[ADDR_W-1:0] : '0;
   assign o_mem_wdata = i_in_data;
   assign o_done      = (r_state == S_DONE);
   // Both sums are cleared together on start, so they are equal for an empty or rejected load.
   assign o_error     = o_done && (r_oversize || (w_rd_sum != w_checksum));
   assign o_core_hold = !(o_done && !o_error);
   assign o_checksum  = w_checksum;

endmodule

// File: tb/tb_imem_loader.sv
// Directed and randomized checks of imem_loader against a word-list/sum reference model
// and a simple synchronous-read imem model that can corrupt one readback word.
module tb_imem_loader;

   localparam int ADDR_W = 5;
   localparam int DATA_W = 32;
   localparam int DEPTH  = 2 ** ADDR_W;

   logic              i_clk = 1'b0;
   logic              i_rst_n = 1'b1;
   logic              i_start = 1'b0;
   logic [ADDR_W:0]   i_word_count = '0;
   logic              i_in_valid = 1'b0;
   logic [DATA_W-1:0] i_in_data = '0;
   logic              o_in_ready;
   logic              o_mem_we;
   logic              o_mem_re;
   logic [ADDR_W-1:0] o_mem_addr;
   logic [DATA_W-1:0] o_mem_wdata;
   logic [DATA_W-1:0] i_mem_rdata;
   logic              o_core_hold;
   logic              o_done;
   logic              o_error;
   logic [DATA_W-1:0] o_checksum;

   int checks = 0;
   int errors = 0;
   int we_count = 0;
   int re_count = 0;
   int overlap = 0;
   bit corrupt = 1'b0;

   logic [DATA_W-1:0] imem  [DEPTH];
   logic [DATA_W-1:0] words [DEPTH];

   always #5 i_clk = ~i_clk;

   imem_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .i_clk        (i_clk),
      .i_rst_n      (i_rst_n),
      .i_start      (i_start),
      .i_word_count (i_word_count),
      .i_in_valid   (i_in_valid),
      .i_in_data    (i_in_data),
      .o_in_ready   (o_in_ready),
      .o_mem_we     (o_mem_we),
      .o_mem_re     (o_mem_re),
      .o_mem_addr   (o_mem_addr),
      .o_mem_wdata  (o_mem_wdata),
      .i_mem_rdata  (i_mem_rdata),
      .o_core_hold  (o_core_hold),
      .o_done       (o_done),
      .o_error      (o_error),
      .o_checksum   (o_checksum)
   );

   // imem model: synchronous write, one-cycle registered read, optional bit-0 flip at addr 2
   always @(posedge i_clk) begin
      if (o_mem_we) imem[o_mem_addr] <= o_mem_wdata;
      if (o_mem_re) i_mem_rdata <= imem[o_mem_addr] ^ {31'b0, (corrupt && o_mem_addr == 5'd2)};
   end

   always @(negedge i_clk) begin
      if (o_mem_we) we_count++;
      if (o_mem_re) re_count++;
      if (o_mem_we && o_mem_re) overlap++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_in_ready"}, o_in_ready, 0);
      chk({tag, "_mem_we"}, o_mem_we, 0);
      chk({tag, "_mem_re"}, o_mem_re, 0);
      chk({tag, "_mem_addr"}, o_mem_addr, 0);
      chk({tag, "_core_hold"}, o_core_hold, 1);
      chk({tag, "_done"}, o_done, 0);
      chk({tag, "_error"}, o_error, 0);
      chk({tag, "_checksum"}, o_checksum, 0);
   endtask

   task automatic start_pulse(input int n);
      @(posedge i_clk); #1;
      i_start = 1'b1;
      i_word_count = n[ADDR_W:0];
      @(posedge i_clk); #1;
      i_start = 1'b0;
      i_word_count = $urandom_range(0, 63);
   endtask

   // Feeds words[0..n-1]; mode 0 = valid always, 1 = valid on alternate cycles, 2 = random.
   task automatic run_load(input int n, input int mode, input bit poke, output int lcyc);
      int idx = 0;
      int c = 0;
      bit v;
      bit rdy;
      while (idx < n && c < 2000) begin
         v = (mode == 0) ? 1'b1 : (mode == 1) ? (c % 2 == 0) : 1'($urandom_range(0, 1));
         i_in_valid = v;
         i_in_data = words[idx];
         i_start = (poke && c == 1);
         i_word_count = '0;
         @(negedge i_clk);
         rdy = o_in_ready;
         chk("load_in_ready", rdy, 1);
         chk("load_mem_we", o_mem_we, v);
         if (v) chk("load_mem_addr", o_mem_addr, idx);
         @(posedge i_clk); #1;
         if (v && rdy) idx++;
         c++;
      end
      i_in_valid = 1'b0;
      i_start = 1'b0;
      lcyc = c;
   endtask

   task automatic do_run(input string tag, input int n, input int mode, input bit preset,
                         input bit poke);
      logic [31:0] exp_sum = 0;
      int we0, re0, lcyc, vcyc, bad;
      bit exp_err;
      if (!preset) for (int i = 0; i < n; i++) words[i] = $urandom;
      for (int i = 0; i < n; i++) exp_sum += words[i];
      exp_err = corrupt && (n > 2);
      we0 = we_count;
      re0 = re_count;
      start_pulse(n);
      chk({tag, "_start_ready"}, o_in_ready, 1);
      chk({tag, "_start_done"}, o_done, 0);
      chk({tag, "_start_hold"}, o_core_hold, 1);
      chk({tag, "_start_error"}, o_error, 0);
      run_load(n, mode, poke, lcyc);
      if (mode == 0) chk({tag, "_load_cycles"}, lcyc, n);
      if (mode == 1) chk({tag, "_load_cycles"}, lcyc, 2 * n - 1);
      vcyc = 0;
      while (!o_done && vcyc < 500) begin
         @(posedge i_clk); #1;
         vcyc++;
      end
      chk({tag, "_verify_cycles"}, vcyc, n + 1);
      chk({tag, "_done"}, o_done, 1);
      chk({tag, "_checksum"}, o_checksum, exp_sum);
      chk({tag, "_error"}, o_error, exp_err);
      chk({tag, "_core_hold"}, o_core_hold, exp_err);
      chk({tag, "_we_count"}, we_count - we0, n);
      chk({tag, "_re_count"}, re_count - re0, n);
      bad = 0;
      for (int i = 0; i < n; i++) if (imem[i] !== words[i]) bad++;
      chk({tag, "_imem_image"}, bad, 0);
      $display("run %s n=%0d mode=%0d load=%0d verify=%0d sum=%08h err=%0d",
               tag, n, mode, lcyc, vcyc, o_checksum, o_error);
   endtask

   initial begin
      int we0;
      logic [31:0] partial0, partial1;
      #3 i_rst_n = 1'b0;
      #10;
      chk_reset_outputs("reset");
      @(negedge i_clk) i_rst_n = 1'b1;

      for (int i = 0; i < 5; i++) words[i] = 100 * (i + 1);
      do_run("basic5", 5, 0, 1'b1, 1'b0);
      do_run("alt5", 5, 1, 1'b1, 1'b1);

      we0 = we_count;
      start_pulse(0);
      chk("zero_done", o_done, 1);
      chk("zero_checksum", o_checksum, 0);
      chk("zero_error", o_error, 0);
      chk("zero_core_hold", o_core_hold, 0);
      chk("zero_we", we_count - we0, 0);
      $display("run zero n=0 done=%0d err=%0d", o_done, o_error);

      we0 = we_count;
      start_pulse(DEPTH + 1 + $urandom_range(0, 30));
      chk("over_done", o_done, 1);
      chk("over_error", o_error, 1);
      chk("over_core_hold", o_core_hold, 1);
      chk("over_we", we_count - we0, 0);
      $display("run oversize done=%0d err=%0d", o_done, o_error);

      corrupt = 1'b1;
      do_run("corrupt", 5, 0, 1'b0, 1'b0);
      corrupt = 1'b0;

      words[0] = 32'hFFFF_FFFF;
      words[1] = 32'd2;
      do_run("wrap", 2, 0, 1'b1, 1'b0);

      do_run("full", DEPTH, 0, 1'b0, 1'b0);
      for (int r = 0; r < 5; r++) do_run("rand", $urandom_range(1, DEPTH), 2, 1'b0, r[0]);

      for (int i = 0; i < 5; i++) words[i] = $urandom;
      partial0 = words[0];
      partial1 = words[1];
      start_pulse(5);
      i_in_valid = 1'b1;
      for (int k = 0; k < 2; k++) begin
         i_in_data = words[k];
         @(posedge i_clk); #1;
      end
      i_in_data = words[2];
      @(negedge i_clk);
      i_rst_n = 1'b0;
      #1;
      chk_reset_outputs("midreset");
      i_in_valid = 1'b0;
      @(negedge i_clk) i_rst_n = 1'b1;
      chk("midreset_imem0", imem[0], partial0);
      chk("midreset_imem1", imem[1], partial1);
      $display("run midreset words_kept=2");
      do_run("post_reset", 2, 0, 1'b0, 1'b0);

      chk("we_re_overlap", overlap, 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
